lsu: RTL and testbench

LSU -- requirements
Module: lsu

---
 rtl/lsu_pkg.sv | 17 +
 rtl/lsu_align.sv | 39 +++
 rtl/lsu.sv | 180 ++++++++++++++++++
 tb/tb_lsu.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared LSU FSM encoding, access-size constants and default watchdog limit
package lsu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_DONE = 2'd2
    } lsu_state_e;

    // Access size encodings on mem_byte_enable (LSB-aligned lane masks)
    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

    localparam int unsigned LSU_TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - combinational load alignment and sign/zero extension
//
// Ports:
//   rdata_i   bus read word as returned by memory
//   offset_i  byte offset of the access within the word (addr[1:0])
//   size_i    LSB-aligned lane mask (byte / half / word)
//   uns_i     1 = zero-extend, 0 = sign-extend
//   result_o  aligned, extended load value
module lsu_align
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH      = 32,
    parameter int BYTE_DATA_WIDTH = 4
) (
    input  logic [DATA_WIDTH-1:0]              rdata_i,
    input  logic [$clog2(BYTE_DATA_WIDTH)-1:0] offset_i,
    input  logic [BYTE_DATA_WIDTH-1:0]         size_i,
    input  logic                               uns_i,
    output logic [DATA_WIDTH-1:0]              result_o
);

    logic [DATA_WIDTH-1:0] shifted;
    logic                  sign_b;
    logic                  sign_h;

    assign shifted = rdata_i >> {offset_i, 3'b000};
    assign sign_b  = ~uns_i & shifted[7];
    assign sign_h  = ~uns_i & shifted[15];

    always_comb begin
        result_o = shifted;
        if (size_i == BYTE_DATA_WIDTH'(BE_BYTE)) begin
            result_o = {{(DATA_WIDTH-8){sign_b}}, shifted[7:0]};
        end else if (size_i == BYTE_DATA_WIDTH'(BE_HALF)) begin
            result_o = {{(DATA_WIDTH-16){sign_h}}, shifted[15:0]};
        end
    end

endmodule

// File: rtl/lsu.sv
// rtl/lsu.sv - load/store unit bridging core memory requests onto a single-beat data bus
//
// Optional feature: define LSU_BUS_TIMEOUT_EN to add a bus watchdog that ends a
// BUS phase with mem_err after TIMEOUT_CYCLES cycles without bus_ack.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   mem_req/we/byte_enable/unsigned/addr/wdata   core request side
//   mem_valid/rdata/err      core completion side (held until mem_req falls)
//   bus_req/we/addr/be/wdata data bus request (word address, lane-positioned data)
//   bus_ack/rdata            data bus one-cycle completion
module lsu
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH      = 32,
    parameter int BYTE_DATA_WIDTH = 4,
    parameter int TIMEOUT_CYCLES  = LSU_TIMEOUT_DEFAULT
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       mem_req,
    input  logic                       mem_we,
    input  logic [BYTE_DATA_WIDTH-1:0] mem_byte_enable,
    input  logic                       mem_unsigned,
    input  logic [DATA_WIDTH-1:0]      mem_addr,
    input  logic [DATA_WIDTH-1:0]      mem_wdata,
    output logic                       mem_valid,
    output logic [DATA_WIDTH-1:0]      mem_rdata,
    output logic                       mem_err,
    output logic                       bus_req,
    output logic                       bus_we,
    output logic [DATA_WIDTH-1:0]      bus_addr,
    output logic [BYTE_DATA_WIDTH-1:0] bus_be,
    output logic [DATA_WIDTH-1:0]      bus_wdata,
    input  logic                       bus_ack,
    input  logic [DATA_WIDTH-1:0]      bus_rdata
);

    localparam int OFF_W = $clog2(BYTE_DATA_WIDTH);

    lsu_state_e                 state_q, state_d;
    logic                       we_q, we_d;
    logic [BYTE_DATA_WIDTH-1:0] size_q, size_d;
    logic [BYTE_DATA_WIDTH-1:0] be_q, be_d;
    logic                       uns_q, uns_d;
    logic [OFF_W-1:0]           off_q, off_d;
    logic [DATA_WIDTH-1:0]      addr_q, addr_d;
    logic [DATA_WIDTH-1:0]      wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]      rdata_q, rdata_d;
    logic                       err_q, err_d;

`ifdef LSU_BUS_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    logic [OFF_W-1:0]      off_in;
    logic                  is_byte, is_half, is_word, legal;
    logic [DATA_WIDTH-1:0] load_data;

    assign off_in  = mem_addr[OFF_W-1:0];
    assign is_byte = (mem_byte_enable == BYTE_DATA_WIDTH'(BE_BYTE));
    assign is_half = (mem_byte_enable == BYTE_DATA_WIDTH'(BE_HALF));
    assign is_word = (mem_byte_enable == BYTE_DATA_WIDTH'(BE_WORD));
    assign legal   = is_byte | (is_half & ~off_in[0]) | (is_word & (off_in == '0));

    lsu_align #(
        .DATA_WIDTH      (DATA_WIDTH),
        .BYTE_DATA_WIDTH (BYTE_DATA_WIDTH)
    ) u_align (
        .rdata_i  (bus_rdata),
        .offset_i (off_q),
        .size_i   (size_q),
        .uns_i    (uns_q),
        .result_o (load_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            we_q    <= 1'b0;
            size_q  <= '0;
            be_q    <= '0;
            uns_q   <= 1'b0;
            off_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
`ifdef LSU_BUS_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            size_q  <= size_d;
            be_q    <= be_d;
            uns_q   <= uns_d;
            off_q   <= off_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
`ifdef LSU_BUS_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        size_d  = size_q;
        be_d    = be_q;
        uns_d   = uns_q;
        off_d   = off_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
`ifdef LSU_BUS_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (mem_req) begin
                    we_d    = mem_we;
                    size_d  = mem_byte_enable;
                    uns_d   = mem_unsigned;
                    off_d   = off_in;
                    addr_d  = {mem_addr[DATA_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
                    be_d    = mem_byte_enable << off_in;
                    wdata_d = mem_wdata << {off_in, 3'b000};
                    rdata_d = '0;
                    // Illegal accesses complete immediately without touching the bus
                    err_d   = ~legal;
                    state_d = legal ? ST_BUS : ST_DONE;
`ifdef LSU_BUS_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            ST_BUS: begin
                if (bus_ack) begin
                    rdata_d = we_q ? '0 : load_data;
                    err_d   = 1'b0;
                    state_d = ST_DONE;
                end
`ifdef LSU_BUS_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            ST_DONE: begin
                if (!mem_req) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Bus outputs are qualified by the BUS state so nothing leaks onto the bus
    // for illegal accesses or after reset.
    assign bus_req   = (state_q == ST_BUS);
    assign bus_we    = bus_req & we_q;
    assign bus_addr  = bus_req ? addr_q : '0;
    assign bus_be    = bus_req ? be_q : '0;
    assign bus_wdata = bus_req ? wdata_q : '0;

    assign mem_valid = (state_q == ST_DONE);
    assign mem_rdata = mem_valid ? rdata_q : '0;
    assign mem_err   = mem_valid & err_q;

endmodule

// File: tb/tb_lsu.sv
// tb/tb_lsu.sv - table-driven self-checking bench for lsu
module tb_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_req, mem_we, mem_unsigned;
    logic [3:0]  mem_byte_enable;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_valid, mem_err;
    logic [31:0] mem_rdata;
    logic        bus_req, bus_we, bus_ack;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic [3:0]  bus_be;

    int n_vec = 0;
    int n_bad = 0;

    lsu #(
        .DATA_WIDTH      (32),
        .BYTE_DATA_WIDTH (4),
        .TIMEOUT_CYCLES  (8)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .mem_req         (mem_req),
        .mem_we          (mem_we),
        .mem_byte_enable (mem_byte_enable),
        .mem_unsigned    (mem_unsigned),
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata),
        .mem_valid       (mem_valid),
        .mem_rdata       (mem_rdata),
        .mem_err         (mem_err),
        .bus_req         (bus_req),
        .bus_we          (bus_we),
        .bus_addr        (bus_addr),
        .bus_be          (bus_be),
        .bus_wdata       (bus_wdata),
        .bus_ack         (bus_ack),
        .bus_rdata       (bus_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        we;
        logic [3:0]  be;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          delay;
        logic [31:0] brdata;
        logic [3:0]  x_be;
        logic [31:0] x_bwdata;
        logic [31:0] x_baddr;
        logic [31:0] x_rdata;
        logic        x_err;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v);
        @(negedge clk);
        mem_req         = 1'b1;
        mem_we          = v.we;
        mem_byte_enable = v.be;
        mem_unsigned    = v.uns;
        mem_addr        = v.addr;
        mem_wdata       = v.wdata;
        @(negedge clk);
        if (!v.x_err) begin
            chk({v.name, " bus_req"},   {31'd0, bus_req}, 32'd1);
            chk({v.name, " bus_we"},    {31'd0, bus_we}, {31'd0, v.we});
            chk({v.name, " bus_addr"},  bus_addr, v.x_baddr);
            chk({v.name, " bus_be"},    {28'd0, bus_be}, {28'd0, v.x_be});
            chk({v.name, " bus_wdata"}, bus_wdata, v.x_bwdata);
            repeat (v.delay) @(negedge clk);
            chk({v.name, " bus_req held"}, {31'd0, bus_req}, 32'd1);
            chk({v.name, " valid early"},  {31'd0, mem_valid}, 32'd0);
            bus_ack   = 1'b1;
            bus_rdata = v.brdata;
            @(negedge clk);
            bus_ack   = 1'b0;
            bus_rdata = 32'hA5A5_A5A5;
        end
        chk({v.name, " mem_valid"}, {31'd0, mem_valid}, 32'd1);
        chk({v.name, " mem_err"},   {31'd0, mem_err}, {31'd0, v.x_err});
        chk({v.name, " mem_rdata"}, mem_rdata, v.x_rdata);
        chk({v.name, " bus_req low"}, {31'd0, bus_req}, 32'd0);
        @(negedge clk);
        chk({v.name, " valid held"}, {31'd0, mem_valid}, 32'd1);
        chk({v.name, " no restart"}, {31'd0, bus_req}, 32'd0);
        mem_req = 1'b0;
        @(negedge clk);
        chk({v.name, " valid drop"}, {31'd0, mem_valid}, 32'd0);
    endtask

    initial begin
        //            name     we    be     uns   addr          wdata         dly brdata        x_be   x_bwdata      x_baddr       x_rdata       x_err
        vecs[0]  = '{"SW100",  1'b1, 4'hF, 1'b0, 32'h0000_0100, 32'hDEAD_BEEF, 3, 32'h1234_5678, 4'hF, 32'hDEAD_BEEF, 32'h0000_0100, 32'h0000_0000, 1'b0};
        vecs[1]  = '{"LB203",  1'b0, 4'h1, 1'b0, 32'h0000_0203, 32'h0000_0000, 1, 32'h80FF_0000, 4'h8, 32'h0000_0000, 32'h0000_0200, 32'hFFFF_FF80, 1'b0};
        vecs[2]  = '{"LBU203", 1'b0, 4'h1, 1'b1, 32'h0000_0203, 32'h0000_0000, 0, 32'h80FF_0000, 4'h8, 32'h0000_0000, 32'h0000_0200, 32'h0000_0080, 1'b0};
        vecs[3]  = '{"LH102",  1'b0, 4'h3, 1'b0, 32'h0000_0102, 32'h0000_0000, 2, 32'h8001_1234, 4'hC, 32'h0000_0000, 32'h0000_0100, 32'hFFFF_8001, 1'b0};
        vecs[4]  = '{"LHU102", 1'b0, 4'h3, 1'b1, 32'h0000_0102, 32'h0000_0000, 0, 32'h8001_1234, 4'hC, 32'h0000_0000, 32'h0000_0100, 32'h0000_8001, 1'b0};
        vecs[5]  = '{"LW101",  1'b0, 4'hF, 1'b0, 32'h0000_0101, 32'h0000_0000, 0, 32'h0000_0000, 4'h0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b1};
        vecs[6]  = '{"SB001",  1'b1, 4'h1, 1'b0, 32'h0000_0001, 32'h0000_00AB, 0, 32'hFFFF_FFFF, 4'h2, 32'h0000_AB00, 32'h0000_0000, 32'h0000_0000, 1'b0};
        vecs[7]  = '{"LW104",  1'b0, 4'hF, 1'b0, 32'h0000_0104, 32'h0000_0000, 1, 32'hCAFE_F00D, 4'hF, 32'h0000_0000, 32'h0000_0104, 32'hCAFE_F00D, 1'b0};
        vecs[8]  = '{"SZ0111", 1'b0, 4'h7, 1'b0, 32'h0000_0000, 32'h0000_0000, 0, 32'h0000_0000, 4'h0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b1};
        vecs[9]  = '{"LH003",  1'b0, 4'h3, 1'b0, 32'h0000_0003, 32'h0000_0000, 0, 32'h0000_0000, 4'h0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b1};
        vecs[10] = '{"SH002",  1'b1, 4'h3, 1'b0, 32'h0000_0002, 32'h0000_1234, 0, 32'h0000_0000, 4'hC, 32'h1234_0000, 32'h0000_0000, 32'h0000_0000, 1'b0};
        vecs[11] = '{"LB000",  1'b0, 4'h1, 1'b0, 32'h0000_0000, 32'h0000_0000, 0, 32'h0000_007F, 4'h1, 32'h0000_0000, 32'h0000_0000, 32'h0000_007F, 1'b0};

        rst             = 1'b1;
        mem_req         = 1'b0;
        mem_we          = 1'b0;
        mem_byte_enable = 4'h0;
        mem_unsigned    = 1'b0;
        mem_addr        = '0;
        mem_wdata       = '0;
        bus_ack         = 1'b0;
        bus_rdata       = '0;

        repeat (2) @(negedge clk);
        chk("rst mem_valid", {31'd0, mem_valid}, 32'd0);
        chk("rst bus_req",   {31'd0, bus_req}, 32'd0);
        chk("rst mem_rdata", mem_rdata, 32'd0);
        chk("rst bus_addr",  bus_addr, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            run_vec(vecs[i]);
        end

        // Reset two cycles into BUS drops bus_req at once
        @(negedge clk);
        mem_req         = 1'b1;
        mem_we          = 1'b0;
        mem_byte_enable = 4'hF;
        mem_addr        = 32'h0000_0010;
        repeat (2) @(negedge clk);
        chk("pre-rst bus_req", {31'd0, bus_req}, 32'd1);
        rst = 1'b1;
        #1;
        chk("mid-rst bus_req",   {31'd0, bus_req}, 32'd0);
        chk("mid-rst mem_valid", {31'd0, mem_valid}, 32'd0);
        mem_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        run_vec(vecs[7]);

        // mem_req dropping during BUS does not abort the transaction
        @(negedge clk);
        mem_req         = 1'b1;
        mem_we          = 1'b0;
        mem_byte_enable = 4'h3;
        mem_unsigned    = 1'b0;
        mem_addr        = 32'h0000_0102;
        @(negedge clk);
        mem_req = 1'b0;
        @(negedge clk);
        chk("drop bus_req", {31'd0, bus_req}, 32'd1);
        bus_ack   = 1'b1;
        bus_rdata = 32'h8001_1234;
        @(negedge clk);
        bus_ack = 1'b0;
        chk("drop mem_valid", {31'd0, mem_valid}, 32'd1);
        chk("drop mem_rdata", mem_rdata, 32'hFFFF_8001);
        @(negedge clk);
        chk("drop done 1cyc", {31'd0, mem_valid}, 32'd0);

        // Stray bus_ack in IDLE is ignored
        bus_ack = 1'b1;
        @(negedge clk);
        bus_ack = 1'b0;
        chk("idle ack valid",   {31'd0, mem_valid}, 32'd0);
        chk("idle ack bus_req", {31'd0, bus_req}, 32'd0);
        run_vec(vecs[2]);

`ifdef LSU_BUS_TIMEOUT_EN
        // Watchdog: no bus_ack, TIMEOUT_CYCLES = 8
        @(negedge clk);
        mem_req         = 1'b1;
        mem_we          = 1'b0;
        mem_byte_enable = 4'hF;
        mem_addr        = 32'h0000_0020;
        repeat (8) @(negedge clk);
        chk("to bus_req cyc8", {31'd0, bus_req}, 32'd1);
        chk("to valid early",  {31'd0, mem_valid}, 32'd0);
        @(negedge clk);
        chk("to mem_valid", {31'd0, mem_valid}, 32'd1);
        chk("to mem_err",   {31'd0, mem_err}, 32'd1);
        chk("to bus_req",   {31'd0, bus_req}, 32'd0);
        chk("to mem_rdata", mem_rdata, 32'd0);
        mem_req = 1'b0;
        @(negedge clk);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
